div_issue_ctrl: RTL and testbench

- Sequences the two multi-cycle divider IPs (signed `div`, unsigned `divu`) on behalf of the EXE stage.
- Captures operands once and runs the per-channel valid/ready operand handshake exactly once per instruction.
- Tracks the in-flight operation, holds the 64-bit result until the stage consumes it, and safely drains an operation whose instruction was flushed.
- Replaces the free-running tvalid/div_is_running logic in EXE; EXE uses `busy`/`res_valid` for es_ready_go and writes HI/LO from `res_*`.

---
 rtl/div_issue_ctrl_pkg.sv | 30 +++
 rtl/div_issue_ctrl_beat.sv | 37 +++
 rtl/div_issue_ctrl.sv | 178 +++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// rtl/div_issue_ctrl_pkg.sv - shared types and constants for the divider issue controller
package div_issue_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } div_state_t;

    // Bit positions inside s_tvalid / s_tready
    localparam int TV_S_DIVISOR  = 0;
    localparam int TV_S_DIVIDEND = 1;
    localparam int TV_U_DIVISOR  = 2;
    localparam int TV_U_DIVIDEND = 3;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_RES_W  = 2 * DIV_DATA_W;

    // Select one channel's bit of a 4-bit handshake vector for the active engine
    function automatic logic pick_lane(input logic [3:0] bits, input logic sel_signed,
                                       input logic is_dividend);
        if (sel_signed)
            return is_dividend ? bits[TV_S_DIVIDEND] : bits[TV_S_DIVISOR];
        else
            return is_dividend ? bits[TV_U_DIVIDEND] : bits[TV_U_DIVISOR];
    endfunction

endpackage

// File: rtl/div_issue_ctrl_beat.sv
// rtl/div_issue_ctrl_beat.sv - one operand channel: single-beat tvalid and accepted flag
module div_beat_tracker (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic flush_drop,
    input  logic tready,
    output logic tvalid,
    output logic accepted,
    output logic handshake
);

    logic pending_q;
    logic accepted_q;

    // A dropped beat is masked in the same cycle so the IP never sees it
    assign tvalid    = pending_q & ~flush_drop;
    assign handshake = tvalid & tready;
    assign accepted  = accepted_q;

    // Arm on start, retire after exactly one handshake, abandon on flush
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= 1'b0;
            accepted_q <= 1'b0;
        end else if (start) begin
            pending_q  <= 1'b1;
            accepted_q <= 1'b0;
        end else if (handshake) begin
            pending_q  <= 1'b0;
            accepted_q <= 1'b1;
        end else if (flush_drop) begin
            pending_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - issues one operand pair to the div/divu IPs and holds the result
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int DATA_W  = DIV_DATA_W,
    parameter int MAX_CYC = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_signed,
    input  logic [DATA_W-1:0]   req_dividend,
    input  logic [DATA_W-1:0]   req_divisor,
    output logic                req_ready,
    input  logic                flush,
    output logic                res_valid,
    output logic [DATA_W-1:0]   res_quotient,
    output logic [DATA_W-1:0]   res_remainder,
    input  logic                res_ack,
    output logic                busy,
    output logic                timeout,
    output logic [DATA_W-1:0]   s_tdata_dividend,
    output logic [DATA_W-1:0]   s_tdata_divisor,
    output logic [3:0]          s_tvalid,
    input  logic [3:0]          s_tready,
    input  logic [1:0]          m_tvalid,
    input  logic [2*DATA_W-1:0] m_tdata_s,
    input  logic [2*DATA_W-1:0] m_tdata_u
);

    localparam int RES_W = 2 * DATA_W;
    localparam int CNT_W = $clog2(MAX_CYC + 1);

    div_state_t        state_q, state_next;
    logic              sel_signed_q;
    logic [DATA_W-1:0] dividend_q, divisor_q;
    logic [DATA_W-1:0] quo_q, rem_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              timeout_q;

    logic              accept, drop, latch;
    logic              dd_tvalid, dd_acc, dd_hs;
    logic              dv_tvalid, dv_acc, dv_hs;
    logic              m_sel;
    logic [RES_W-1:0]  m_data_sel;
    logic              both_done;

    assign m_sel      = sel_signed_q ? m_tvalid[0] : m_tvalid[1];
    assign m_data_sel = sel_signed_q ? m_tdata_s : m_tdata_u;
    assign both_done  = (dd_acc | dd_hs) & (dv_acc | dv_hs);

    div_beat_tracker u_dividend (
        .clk        (clk),
        .reset      (reset),
        .start      (accept),
        .flush_drop (drop),
        .tready     (pick_lane(s_tready, sel_signed_q, 1'b1)),
        .tvalid     (dd_tvalid),
        .accepted   (dd_acc),
        .handshake  (dd_hs)
    );

    div_beat_tracker u_divisor (
        .clk        (clk),
        .reset      (reset),
        .start      (accept),
        .flush_drop (drop),
        .tready     (pick_lane(s_tready, sel_signed_q, 1'b0)),
        .tvalid     (dv_tvalid),
        .accepted   (dv_acc),
        .handshake  (dv_hs)
    );

    // Next-state decode; flush only abandons beats when the IP holds no partial operand
    always_comb begin
        state_next = state_q;
        accept     = 1'b0;
        drop       = 1'b0;
        latch      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    accept     = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (flush) begin
                    if (!(dd_acc || dv_acc)) begin
                        drop       = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_DRAIN;
                    end
                end else if (both_done) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A dout arriving with the flush is already the one to discard
                if (flush)
                    state_next = m_sel ? ST_IDLE : ST_DRAIN;
                else if (m_sel) begin
                    latch      = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush || res_ack)
                    state_next = ST_IDLE;
            end
            ST_DRAIN: begin
                if (m_sel)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_next;
    end

    // Operand capture, result hold, watchdog counter and sticky timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_signed_q <= 1'b0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            if (accept) begin
                sel_signed_q <= req_signed;
                dividend_q   <= req_dividend;
                divisor_q    <= req_divisor;
            end
            if (latch) begin
                quo_q <= m_data_sel[RES_W-1:DATA_W];
                rem_q <= m_data_sel[DATA_W-1:0];
            end
            if (state_q == ST_SEND && state_next == ST_WAIT)
                cnt_q <= '0;
            else if (state_q == ST_WAIT && cnt_q != CNT_W'(MAX_CYC))
                cnt_q <= cnt_q + 1'b1;
            if (state_q == ST_WAIT && cnt_q == CNT_W'(MAX_CYC - 1))
                timeout_q <= 1'b1;
        end
    end

    // Route the channel valids onto the selected engine's lanes only
    always_comb begin
        s_tvalid = 4'b0000;
        if (sel_signed_q) begin
            s_tvalid[TV_S_DIVIDEND] = dd_tvalid;
            s_tvalid[TV_S_DIVISOR]  = dv_tvalid;
        end else begin
            s_tvalid[TV_U_DIVIDEND] = dd_tvalid;
            s_tvalid[TV_U_DIVISOR]  = dv_tvalid;
        end
    end

    assign req_ready        = (state_q == ST_IDLE);
    assign busy             = (state_q != ST_IDLE);
    assign res_valid        = (state_q == ST_DONE);
    assign res_quotient     = quo_q;
    assign res_remainder    = rem_q;
    assign timeout          = timeout_q;
    assign s_tdata_dividend = dividend_q;
    assign s_tdata_divisor  = divisor_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed self-checking bench for div_issue_ctrl
module tb_div_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_signed;
    logic [31:0] req_dividend;
    logic [31:0] req_divisor;
    logic        req_ready;
    logic        flush;
    logic        res_valid;
    logic [31:0] res_quotient;
    logic [31:0] res_remainder;
    logic        res_ack;
    logic        busy;
    logic        timeout;
    logic [31:0] s_tdata_dividend;
    logic [31:0] s_tdata_divisor;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tready;
    logic [1:0]  m_tvalid;
    logic [63:0] m_tdata_s;
    logic [63:0] m_tdata_u;

    int checks   = 0;
    int failures = 0;

    div_issue_ctrl #(.DATA_W(32), .MAX_CYC(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_signed       (req_signed),
        .req_dividend     (req_dividend),
        .req_divisor      (req_divisor),
        .req_ready        (req_ready),
        .flush            (flush),
        .res_valid        (res_valid),
        .res_quotient     (res_quotient),
        .res_remainder    (res_remainder),
        .res_ack          (res_ack),
        .busy             (busy),
        .timeout          (timeout),
        .s_tdata_dividend (s_tdata_dividend),
        .s_tdata_divisor  (s_tdata_divisor),
        .s_tvalid         (s_tvalid),
        .s_tready         (s_tready),
        .m_tvalid         (m_tvalid),
        .m_tdata_s        (m_tdata_s),
        .m_tdata_u        (m_tdata_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset;
        reset = 1'b1; req_valid = 1'b0; req_signed = 1'b0;
        req_dividend = '0; req_divisor = '0; flush = 1'b0; res_ack = 1'b0;
        s_tready = '0; m_tvalid = '0; m_tdata_s = '0; m_tdata_u = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Presents one request for a single cycle; returns at the first SEND negedge
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1; req_signed = sgn; req_dividend = a; req_divisor = b;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
        checks++; if (s_tvalid !== 4'b0000) begin failures++; $display("FAIL rst_s_tvalid got=%b exp=0000", s_tvalid); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
        checks++; if ({res_quotient, res_remainder, s_tdata_dividend, s_tdata_divisor} !== 128'h0) begin
            failures++; $display("FAIL rst_data got=%h/%h/%h/%h exp=0", res_quotient, res_remainder, s_tdata_dividend, s_tdata_divisor);
        end
    endtask

    task automatic test_signed;
        logic u_seen, early;
        u_seen = 1'b0; early = 1'b0;
        do_reset();
        s_tready = 4'hF;
        issue(1'b1, 32'd7, 32'hFFFFFFFE);
        #1;
        checks++; if (s_tvalid !== 4'b0011) begin failures++; $display("FAIL sg_send_tvalid got=%b exp=0011", s_tvalid); end
        checks++; if (s_tdata_divisor !== 32'hFFFFFFFE) begin failures++; $display("FAIL sg_tdata got=%h exp=fffffffe", s_tdata_divisor); end
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            m_tvalid = (c == 10) ? 2'b10 : 2'b00;
            m_tdata_u = (c == 10) ? 64'hDEADBEEF_CAFEF00D : 64'h0;
            if (c == 34) begin
                m_tvalid  = 2'b01;
                m_tdata_s = {32'hFFFFFFFD, 32'h00000001};
            end
            #1;
            if (s_tvalid[3:2] !== 2'b00) u_seen = 1'b1;
            if (res_valid !== 1'b0) early = 1'b1;
        end
        checks++; if (u_seen !== 1'b0) begin failures++; $display("FAIL sg_u_tvalid got=1 exp=0"); end
        checks++; if (early !== 1'b0) begin failures++; $display("FAIL sg_early_res got=1 exp=0"); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            m_tvalid = 2'b00;
            res_ack = (k == 3);
            #1;
            checks++;
            if (res_valid !== 1'b1 || res_quotient !== 32'hFFFFFFFD || res_remainder !== 32'h1) begin
                failures++; $display("FAIL sg_result k=%0d got=%b %h %h exp=1 fffffffd 00000001", k, res_valid, res_quotient, res_remainder);
            end
        end
        @(negedge clk);
        res_ack = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++; $display("FAIL sg_after_ack got=%b/%b exp=0/1", res_valid, req_ready);
        end
    endtask

    task automatic test_unsigned;
        int beats_dd, beats_dv;
        beats_dd = 0; beats_dv = 0;
        do_reset();
        s_tready = 4'b1000;
        issue(1'b0, 32'hFFFFFFFF, 32'h10);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            s_tready = (c >= 3) ? 4'b1100 : 4'b1000;
            #1;
            if (c == 0) begin
                checks++; if (s_tvalid !== 4'b1100) begin failures++; $display("FAIL us_tvalid0 got=%b exp=1100", s_tvalid); end
            end
            if (c == 1) begin
                checks++; if (s_tvalid !== 4'b0100) begin failures++; $display("FAIL us_tvalid1 got=%b exp=0100", s_tvalid); end
            end
            if (c == 4) begin
                checks++; if (s_tvalid !== 4'b0000) begin failures++; $display("FAIL us_tvalid4 got=%b exp=0000", s_tvalid); end
            end
            if (s_tvalid[3] && s_tready[3]) beats_dd++;
            if (s_tvalid[2] && s_tready[2]) beats_dv++;
        end
        checks++; if (beats_dd != 1 || beats_dv != 1) begin failures++; $display("FAIL us_beats got=%0d/%0d exp=1/1", beats_dd, beats_dv); end
        @(negedge clk);
        m_tvalid = 2'b10; m_tdata_u = {32'h0FFFFFFF, 32'h0000000F};
        @(negedge clk);
        m_tvalid = 2'b00;
        #1;
        checks++; if (res_valid !== 1'b1 || res_quotient !== 32'h0FFFFFFF || res_remainder !== 32'hF) begin
            failures++; $display("FAIL us_result got=%b %h %h exp=1 0fffffff 0000000f", res_valid, res_quotient, res_remainder);
        end
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
    endtask

    task automatic test_flush_wait;
        do_reset();
        s_tready = 4'hF;
        issue(1'b1, 32'd50, 32'd5);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b1; req_signed = 1'b0; req_dividend = 32'd100; req_divisor = 32'd7;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL fw_drain c=%0d got=%b/%b exp=0/1", c, req_ready, busy); end
        end
        @(negedge clk);
        m_tvalid = 2'b01; m_tdata_s = {32'd10, 32'd0};
        #1;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL fw_stale_valid got=%b exp=0", res_valid); end
        @(negedge clk);
        m_tvalid = 2'b00;
        #1;
        checks++; if (req_ready !== 1'b1 || res_quotient !== 32'd0) begin
            failures++; $display("FAIL fw_idle got=%b %h exp=1 00000000", req_ready, res_quotient);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++; if (s_tvalid !== 4'b1100 || s_tdata_dividend !== 32'd100) begin
            failures++; $display("FAIL fw_send2 got=%b %h exp=1100 00000064", s_tvalid, s_tdata_dividend);
        end
        repeat (3) @(negedge clk);
        m_tvalid = 2'b10; m_tdata_u = {32'd14, 32'd2};
        @(negedge clk);
        m_tvalid = 2'b00;
        #1;
        checks++; if (res_valid !== 1'b1 || res_quotient !== 32'd14 || res_remainder !== 32'd2) begin
            failures++; $display("FAIL fw_result got=%b %0d %0d exp=1 14 2", res_valid, res_quotient, res_remainder);
        end
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
    endtask

    task automatic test_flush_send;
        logic seen;
        int   beats_dv;
        seen = 1'b0; beats_dv = 0;
        do_reset();
        s_tready = 4'b0010;
        issue(1'b1, 32'd9, 32'd3);
        #1;
        checks++; if (s_tvalid !== 4'b0011) begin failures++; $display("FAIL fs_tvalid0 got=%b exp=0011", s_tvalid); end
        @(negedge clk);
        flush = 1'b1; s_tready = 4'b0000;
        #1;
        checks++; if (s_tvalid !== 4'b0001) begin failures++; $display("FAIL fs_flush_tvalid got=%b exp=0001", s_tvalid); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            flush = 1'b0;
            s_tready = (c == 1) ? 4'b0001 : 4'b0000;
            m_tvalid = (c == 4) ? 2'b01 : 2'b00;
            m_tdata_s = {32'd3, 32'd0};
            #1;
            if (s_tvalid[0] && s_tready[0]) beats_dv++;
            if (res_valid) seen = 1'b1;
            if (c == 0) begin
                checks++; if (s_tvalid !== 4'b0001 || req_ready !== 1'b0) begin failures++; $display("FAIL fs_drain got=%b %b exp=0001 0", s_tvalid, req_ready); end
            end
            if (c == 2) begin
                checks++; if (s_tvalid !== 4'b0000) begin failures++; $display("FAIL fs_after_beat got=%b exp=0000", s_tvalid); end
            end
            if (c == 5) begin
                checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL fs_idle got=%b/%b exp=1/0", req_ready, busy); end
            end
        end
        checks++; if (seen !== 1'b0 || beats_dv != 1 || res_quotient !== 32'd0) begin
            failures++; $display("FAIL fs_summary got=%b %0d %h exp=0 1 00000000", seen, beats_dv, res_quotient);
        end
        // Flush before any beat: a ready IP must not see a beat at all
        issue(1'b0, 32'd1, 32'd1);
        s_tready = 4'hF; flush = 1'b1;
        #1;
        checks++; if (s_tvalid !== 4'b0000) begin failures++; $display("FAIL fs_early_gate got=%b exp=0000", s_tvalid); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || s_tvalid !== 4'b0000) begin failures++; $display("FAIL fs_early_idle got=%b %b exp=1 0000", req_ready, s_tvalid); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        s_tready = 4'hF;
        issue(1'b0, 32'd20, 32'd3);
        @(negedge clk);
        m_tvalid = 2'b10; m_tdata_u = {32'd6, 32'd2};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            m_tvalid = 2'b00; m_tdata_u = 64'h0;
            #1;
            checks++; if (res_valid !== 1'b1 || res_quotient !== 32'd6 || res_remainder !== 32'd2) begin
                failures++; $display("FAIL bb_hold k=%0d got=%b %0d %0d exp=1 6 2", k, res_valid, res_quotient, res_remainder);
            end
        end
        @(negedge clk);
        res_ack = 1'b1; req_valid = 1'b1; req_signed = 1'b1; req_dividend = 32'd8; req_divisor = 32'd2;
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bb_done_ready got=%b exp=0", req_ready); end
        @(negedge clk);
        res_ack = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL bb_bubble got=%b/%b exp=0/1", res_valid, req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++; if (s_tvalid !== 4'b0011 || s_tdata_dividend !== 32'd8) begin
            failures++; $display("FAIL bb_accept got=%b %0d exp=0011 8", s_tvalid, s_tdata_dividend);
        end
    endtask

    task automatic test_timeout;
        do_reset();
        s_tready = 4'hF;
        issue(1'b1, 32'hFFFFFFEC, 32'd5);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            checks++; if (timeout !== ((k >= 8) ? 1'b1 : 1'b0)) begin
                failures++; $display("FAIL to_flag k=%0d got=%b exp=%b", k, timeout, (k >= 8));
            end
        end
        @(negedge clk);
        m_tvalid = 2'b01; m_tdata_s = {32'hFFFFFFFC, 32'h0};
        @(negedge clk);
        m_tvalid = 2'b00;
        #1;
        checks++; if (res_valid !== 1'b1 || res_quotient !== 32'hFFFFFFFC || res_remainder !== 32'h0 || timeout !== 1'b1) begin
            failures++; $display("FAIL to_result got=%b %h %h %b exp=1 fffffffc 00000000 1", res_valid, res_quotient, res_remainder, timeout);
        end
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        issue(1'b0, 32'd9, 32'd4);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || s_tvalid !== 4'b0000 || res_valid !== 1'b0 || timeout !== 1'b0) begin
            failures++; $display("FAIL to_reset_ctl got=%b %b %b %b %b exp=1 0 0000 0 0", req_ready, busy, s_tvalid, res_valid, timeout);
        end
        checks++; if ({res_quotient, res_remainder, s_tdata_dividend, s_tdata_divisor} !== 128'h0) begin
            failures++; $display("FAIL to_reset_data got=%h %h %h %h exp=0", res_quotient, res_remainder, s_tdata_dividend, s_tdata_divisor);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_flush_wait();
        test_flush_send();
        test_back_to_back();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end

endmodule
